jtag_tapc: RTL and testbench

JTAG TAP controller for the debug/test port: runs the 16-state IEEE 1149.1 TAP state machine on TCK, holds the instruction register, and decodes the instruction into the data-register select and clock-enable strobes. It sits directly upstream of the bypass cell and boundary-scan chain, driving their shift and clock controls, and multiplexes their serial outputs onto TDO.

---
 rtl/jtag_tapc.sv | 206 ++++++++++++++++++++
 tb/tb_jtag_tapc.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/jtag_tapc.sv
// -----------------------------------------------------------------------------
// jtag_tapc - IEEE 1149.1 TAP controller
//
// Runs the 16-state TAP state machine on tck_i and holds the instruction
// register. It decodes the active instruction into shift, clock and update
// strobes for the external bypass cell and boundary-scan register. It also
// multiplexes the serial outputs of those registers onto tdo_o.
//
// Optional feature macro: JTAG_IDCODE_EN
//   defined   - 32-bit IDCODE register and IDCODE opcode (1) are built, and
//               the reset/TLR instruction is IDCODE.
//   undefined - no IDCODE register; opcode 1 decodes as BYPASS, and the
//               reset/TLR instruction is BYPASS.
//
// Parameters:
//   IR_WIDTH    instruction register width (>= 2)
//   IDCODE_VAL  device identification code (bit 0 must be 1)
//
// Ports:
//   tck_i        in   test clock
//   trst_i       in   asynchronous active-high TAP reset
//   tms_i        in   test mode select (sampled on posedge tck_i)
//   tdi_i        in   serial data in
//   tdo_o        out  serial data out (registered on negedge tck_i)
//   tdo_en_o     out  TDO drive enable, high in SHIFT_IR/SHIFT_DR (negedge)
//   by_tdo_i     in   serial out of the bypass cell
//   bsr_tdo_i    in   serial out of the boundary-scan chain
//   by_shift_o   out  bypass shift/capture select
//   by_clock_o   out  bypass clock enable
//   bsr_shift_o  out  BSR shift select
//   bsr_clock_o  out  BSR clock enable
//   bsr_update_o out  BSR update strobe
//   bsr_mode_o   out  BSR drives pins (EXTEST active)
//   state_o      out  current TAP state code
// -----------------------------------------------------------------------------
module jtag_tapc #(
   parameter int          IR_WIDTH   = 4,
   parameter logic [31:0] IDCODE_VAL = 32'h1000_0A6B
) (
   input  logic       tck_i,
   input  logic       trst_i,
   input  logic       tms_i,
   input  logic       tdi_i,
   output logic       tdo_o,
   output logic       tdo_en_o,
   input  logic       by_tdo_i,
   input  logic       bsr_tdo_i,
   output logic       by_shift_o,
   output logic       by_clock_o,
   output logic       bsr_shift_o,
   output logic       bsr_clock_o,
   output logic       bsr_update_o,
   output logic       bsr_mode_o,
   output logic [3:0] state_o
);

   typedef enum logic [3:0] {
      TLR      = 4'hF,
      RTI      = 4'hC,
      SEL_DR   = 4'h7,
      CAP_DR   = 4'h6,
      SHIFT_DR = 4'h2,
      EXIT1_DR = 4'h1,
      PAUSE_DR = 4'h3,
      EXIT2_DR = 4'h0,
      UPD_DR   = 4'h5,
      SEL_IR   = 4'h4,
      CAP_IR   = 4'hE,
      SHIFT_IR = 4'hA,
      EXIT1_IR = 4'h9,
      PAUSE_IR = 4'hB,
      EXIT2_IR = 4'h8,
      UPD_IR   = 4'hD
   } tap_state_t;

   localparam logic [IR_WIDTH-1:0] OP_EXTEST  = '0;
   localparam logic [IR_WIDTH-1:0] OP_SAMPLE  = IR_WIDTH'(2);
   localparam logic [IR_WIDTH-1:0] OP_BYPASS  = '1;
   localparam logic [IR_WIDTH-1:0] IR_CAPTURE = IR_WIDTH'(1);
`ifdef JTAG_IDCODE_EN
   localparam logic [IR_WIDTH-1:0] OP_IDCODE  = IR_WIDTH'(1);
   localparam logic [IR_WIDTH-1:0] IR_RESET   = OP_IDCODE;
`else
   localparam logic [IR_WIDTH-1:0] IR_RESET   = OP_BYPASS;
`endif

   // Elaboration-time sanity check of the configuration.
   if (IR_WIDTH < 2 || IDCODE_VAL[0] != 1'b1) begin : g_bad_cfg
      $error("jtag_tapc: IR_WIDTH must be >= 2 and IDCODE_VAL[0] must be 1");
   end

   tap_state_t          state_reg;
   logic [IR_WIDTH-1:0] ir_shift_reg;
   logic [IR_WIDTH-1:0] ir_reg;
   logic                tdo_reg;
   logic                tdo_en_reg;

   logic sel_bsr;
   logic sel_by;
   logic dr_tdo;

   // ---------------------------------------------------------------- TAP FSM
   always_ff @(posedge tck_i or posedge trst_i) begin
      if (trst_i) begin
         state_reg <= TLR;
      end else begin
         case (state_reg)
            TLR:      state_reg <= tms_i ? TLR      : RTI;
            RTI:      state_reg <= tms_i ? SEL_DR   : RTI;
            SEL_DR:   state_reg <= tms_i ? SEL_IR   : CAP_DR;
            CAP_DR:   state_reg <= tms_i ? EXIT1_DR : SHIFT_DR;
            SHIFT_DR: state_reg <= tms_i ? EXIT1_DR : SHIFT_DR;
            EXIT1_DR: state_reg <= tms_i ? UPD_DR   : PAUSE_DR;
            PAUSE_DR: state_reg <= tms_i ? EXIT2_DR : PAUSE_DR;
            EXIT2_DR: state_reg <= tms_i ? UPD_DR   : SHIFT_DR;
            UPD_DR:   state_reg <= tms_i ? SEL_DR   : RTI;
            SEL_IR:   state_reg <= tms_i ? TLR      : CAP_IR;
            CAP_IR:   state_reg <= tms_i ? EXIT1_IR : SHIFT_IR;
            SHIFT_IR: state_reg <= tms_i ? EXIT1_IR : SHIFT_IR;
            EXIT1_IR: state_reg <= tms_i ? UPD_IR   : PAUSE_IR;
            PAUSE_IR: state_reg <= tms_i ? EXIT2_IR : PAUSE_IR;
            EXIT2_IR: state_reg <= tms_i ? UPD_IR   : SHIFT_IR;
            UPD_IR:   state_reg <= tms_i ? SEL_DR   : RTI;
            default:  state_reg <= TLR;
         endcase
      end
   end

   // ---------------------------------------------------- instruction register
   // The active IR only changes in UPD_IR or TLR, so an aborted IR scan
   // (trst or a TMS walk to TLR) never leaves a half-shifted opcode active.
   always_ff @(posedge tck_i or posedge trst_i) begin
      if (trst_i) begin
         ir_shift_reg <= '0;
         ir_reg       <= IR_RESET;
      end else begin
         case (state_reg)
            CAP_IR:   ir_shift_reg <= IR_CAPTURE;
            SHIFT_IR: ir_shift_reg <= {tdi_i, ir_shift_reg[IR_WIDTH-1:1]};
            default:  ir_shift_reg <= ir_shift_reg;
         endcase
         if (state_reg == TLR)
            ir_reg <= IR_RESET;
         else if (state_reg == UPD_IR)
            ir_reg <= ir_shift_reg;
      end
   end

   // --------------------------------------------------------------- decoding
   assign sel_bsr = (ir_reg == OP_EXTEST) || (ir_reg == OP_SAMPLE);

`ifdef JTAG_IDCODE_EN
   logic        sel_id;
   logic [31:0] idcode_reg;

   assign sel_id = (ir_reg == OP_IDCODE);
   assign sel_by = !sel_bsr && !sel_id;

   always_ff @(posedge tck_i or posedge trst_i) begin
      if (trst_i) begin
         idcode_reg <= '0;
      end else if (sel_id && state_reg == CAP_DR) begin
         idcode_reg <= IDCODE_VAL;
      end else if (sel_id && state_reg == SHIFT_DR) begin
         idcode_reg <= {tdi_i, idcode_reg[31:1]};
      end
   end

   assign dr_tdo = sel_bsr ? bsr_tdo_i : (sel_id ? idcode_reg[0] : by_tdo_i);
`else
   // Every opcode other than EXTEST/SAMPLE, including 1, selects bypass.
   assign sel_by = !sel_bsr;
   assign dr_tdo = sel_bsr ? bsr_tdo_i : by_tdo_i;
`endif

   // Strobes are combinational so they follow the state in the same cycle.
   assign by_shift_o   = sel_by  && (state_reg == SHIFT_DR);
   assign by_clock_o   = sel_by  && (state_reg == SHIFT_DR || state_reg == CAP_DR);
   assign bsr_shift_o  = sel_bsr && (state_reg == SHIFT_DR);
   assign bsr_clock_o  = sel_bsr && (state_reg == SHIFT_DR || state_reg == CAP_DR);
   assign bsr_update_o = sel_bsr && (state_reg == UPD_DR);
   assign bsr_mode_o   = (ir_reg == OP_EXTEST);
   assign state_o      = state_reg;

   // -------------------------------------------------------------- TDO stage
   // Registered on the falling edge so the value is stable around the next
   // rising edge at the downstream device.
   always_ff @(negedge tck_i or posedge trst_i) begin
      if (trst_i) begin
         tdo_reg    <= 1'b0;
         tdo_en_reg <= 1'b0;
      end else begin
         tdo_en_reg <= (state_reg == SHIFT_IR) || (state_reg == SHIFT_DR);
         if (state_reg == SHIFT_IR)
            tdo_reg <= ir_shift_reg[0];
         else if (state_reg == SHIFT_DR)
            tdo_reg <= dr_tdo;
         else
            tdo_reg <= 1'b0;
      end
   end

   assign tdo_o    = tdo_reg;
   assign tdo_en_o = tdo_en_reg;

endmodule

// File: tb/tb_jtag_tapc.sv
// -----------------------------------------------------------------------------
// tb_jtag_tapc - directed self-checking bench for jtag_tapc.
// A behavioural bypass cell closes the bypass loop; expected TDO bits are
// pushed to a queue as each bit is driven and popped when TDO is sampled.
// -----------------------------------------------------------------------------
module tb_jtag_tapc;

   localparam int          IR_WIDTH   = 4;
   localparam logic [31:0] IDCODE_VAL = 32'h1000_0A6B;

   logic       tck = 1'b0;
   logic       trst;
   logic       tms;
   logic       tdi;
   logic       tdo;
   logic       tdo_en;
   logic       by_tdo;
   logic       bsr_tdo;
   logic       by_shift;
   logic       by_clock;
   logic       bsr_shift;
   logic       bsr_clock;
   logic       bsr_update;
   logic       bsr_mode;
   logic [3:0] state;

   int n_tests = 0;
   int n_fail  = 0;

   logic s_tdo;
   logic s_tdo_en;
   logic exp_q[$];
   logic by_cell = 1'b0;

   jtag_tapc #(.IR_WIDTH(IR_WIDTH), .IDCODE_VAL(IDCODE_VAL)) dut (
      .tck_i        (tck),
      .trst_i       (trst),
      .tms_i        (tms),
      .tdi_i        (tdi),
      .tdo_o        (tdo),
      .tdo_en_o     (tdo_en),
      .by_tdo_i     (by_tdo),
      .bsr_tdo_i    (bsr_tdo),
      .by_shift_o   (by_shift),
      .by_clock_o   (by_clock),
      .bsr_shift_o  (bsr_shift),
      .bsr_clock_o  (bsr_clock),
      .bsr_update_o (bsr_update),
      .bsr_mode_o   (bsr_mode),
      .state_o      (state)
   );

   always #5 tck = ~tck;

   // Bypass cell: captures 0, shifts tdi when clocked.
   always @(posedge tck) begin
      if (by_clock) by_cell <= by_shift & tdi;
   end
   assign by_tdo = by_cell;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
      $display("[TB] %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   // One TCK: drive at posedge+1, sample TDO at negedge+1, return at posedge+1.
   task automatic step(input logic t_ms, input logic t_di);
      tms = t_ms;
      tdi = t_di;
      @(negedge tck);
      #1;
      s_tdo    = tdo;
      s_tdo_en = tdo_en;
      @(posedge tck);
      #1;
   endtask

   task automatic shift_seq(input int n, input logic [63:0] din,
                            input logic [63:0] dexp, input string tag);
      logic e;
      for (int i = 0; i < n; i++) begin
         exp_q.push_back(dexp[i]);
         step(i == n - 1, din[i]);
         e = exp_q.pop_front();
         check($sformatf("%s[%0d]", tag, i), {31'b0, s_tdo}, {31'b0, e});
      end
   endtask

   // RTI -> IR scan of op -> RTI; TDO must show the capture pattern 0..01.
   task automatic ir_scan(input logic [IR_WIDTH-1:0] op);
      step(1, 0);
      step(1, 0);
      step(0, 0);
      step(0, 0);
      shift_seq(IR_WIDTH, {{(64-IR_WIDTH){1'b0}}, op}, 64'h1, "ir_tdo");
      check("ir_tdo_en", {31'b0, s_tdo_en}, 32'h1);
      step(1, 0);
      step(0, 0);
   endtask

   task automatic decode_chk(input logic [IR_WIDTH-1:0] op, input logic by_e,
                             input logic bsr_e, input logic mode_e);
      ir_scan(op);
      check($sformatf("op%0h_mode", op), {31'b0, bsr_mode}, {31'b0, mode_e});
      step(1, 0);
      step(0, 0);
      check($sformatf("op%0h_by_clock", op), {31'b0, by_clock}, {31'b0, by_e});
      check($sformatf("op%0h_bsr_clock", op), {31'b0, bsr_clock}, {31'b0, bsr_e});
      step(1, 0);
      step(1, 0);
      check($sformatf("op%0h_bsr_update", op), {31'b0, bsr_update}, {31'b0, bsr_e});
      step(0, 0);
   endtask

   initial begin
      logic [7:0]  pat;
      logic [63:0] din;
      logic [63:0] dexp;
      logic        id_en;
`ifdef JTAG_IDCODE_EN
      id_en = 1'b1;
`else
      id_en = 1'b0;
`endif
      trst    = 1'b1;
      tms     = 1'b1;
      tdi     = 1'b0;
      bsr_tdo = 1'b0;

      // Reset state
      repeat (2) @(posedge tck);
      #1;
      check("rst_state", {28'b0, state}, 32'hF);
      check("rst_tdo_en", {31'b0, tdo_en}, 32'h0);
      check("rst_tdo", {31'b0, tdo}, 32'h0);
      check("rst_bsr_mode", {31'b0, bsr_mode}, 32'h0);
      trst = 1'b0;
      step(0, 0);
      check("tlr_to_rti", {28'b0, state}, 32'hC);

      // Five TMS=1 reach TLR
      for (int i = 0; i < 5; i++) step(1, 0);
      check("tms5_tlr", {28'b0, state}, 32'hF);
      step(0, 0);

      // Reset instruction: DR scan of 32 bits with tdi=0
      step(1, 0);
      step(0, 0);
      step(0, 0);
      dexp = id_en ? {32'b0, IDCODE_VAL} : 64'h0;
      shift_seq(32, 64'h0, dexp, "idcode");
      step(1, 0);
      step(0, 0);

      // IR scan 1111 -> BYPASS, then bypass DR scan of 10110011
      ir_scan('1);
      check("byp_rti_clock", {31'b0, by_clock}, 32'h0);
      step(1, 0);
      check("byp_sel_clock", {31'b0, by_clock}, 32'h0);
      step(0, 0);
      check("byp_cap_clock", {31'b0, by_clock}, 32'h1);
      check("byp_cap_shift", {31'b0, by_shift}, 32'h0);
      step(0, 0);
      check("byp_shift_clock", {31'b0, by_clock}, 32'h1);
      check("byp_shift_shift", {31'b0, by_shift}, 32'h1);
      pat  = 8'b10110011;
      din  = '0;
      dexp = '0;
      for (int i = 0; i < 8; i++) din[i] = pat[7-i];
      for (int i = 1; i < 8; i++) dexp[i] = din[i-1];
      shift_seq(8, din, dexp, "bypass");
      check("byp_exit_clock", {31'b0, by_clock}, 32'h0);
      step(1, 0);
      check("byp_upd_update", {31'b0, bsr_update}, 32'h0);
      step(0, 0);

      // Decode of other opcodes
      decode_chk(4'b0101, 1'b1, 1'b0, 1'b0);
      decode_chk(4'b0010, 1'b0, 1'b1, 1'b0);
      decode_chk(4'b0001, !id_en, 1'b0, 1'b0);

      // EXTEST: mode, BSR strobes, TDO from BSR, one-cycle update
      ir_scan('0);
      check("ext_mode", {31'b0, bsr_mode}, 32'h1);
      step(1, 0);
      step(0, 0);
      check("ext_cap_clock", {31'b0, bsr_clock}, 32'h1);
      check("ext_cap_shift", {31'b0, bsr_shift}, 32'h0);
      step(0, 0);
      check("ext_shift_shift", {31'b0, bsr_shift}, 32'h1);
      bsr_tdo = 1'b1;
      shift_seq(4, 64'h0, 64'hF, "ext_tdo");
      bsr_tdo = 1'b0;
      check("ext_exit_update", {31'b0, bsr_update}, 32'h0);
      step(1, 0);
      check("ext_upd_state", {28'b0, state}, 32'h5);
      check("ext_upd_update", {31'b0, bsr_update}, 32'h1);
      step(0, 0);
      check("ext_rti_update", {31'b0, bsr_update}, 32'h0);

      // trst during SHIFT_IR aborts and restores the reset instruction
      step(1, 0);
      step(1, 0);
      step(0, 0);
      step(0, 0);
      step(0, 1);
      step(0, 1);
      check("abort_pre_mode", {31'b0, bsr_mode}, 32'h1);
      #2;
      trst = 1'b1;
      #1;
      check("abort_mode", {31'b0, bsr_mode}, 32'h0);
      check("abort_state", {28'b0, state}, 32'hF);
      check("abort_tdo_en", {31'b0, tdo_en}, 32'h0);
      @(negedge tck);
      #1;
      trst = 1'b0;
      @(posedge tck);
      #1;
      step(0, 0);
      step(1, 0);
      step(0, 0);
      step(0, 0);
      dexp = id_en ? {62'b0, IDCODE_VAL[1:0]} : 64'h0;
      shift_seq(2, 64'h0, dexp, "abort_dr");
      check("abort_post_mode", {31'b0, bsr_mode}, 32'h0);
      step(1, 0);
      step(0, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL timeout");
      $fatal(1, "timeout");
   end

endmodule
